// File: rtl/mux8_arb_pkg.sv
// Shared constants for the 8-way round-robin selector: state encoding and sizes.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: the first set request found when scanning
// from ptr upward, with wrap from 7 to 0.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so that position ptr lands on bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  // Rotate the winner back into absolute numbering (the 3-bit add wraps).
  assign any    = |req;
  assign idx    = off + ptr;
  assign onehot = idx2onehot(idx);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of one 8:1 data selector: registered one-hot grant and select.
// Optional build macro RR_BURST_LIMIT_EN caps an owner's tenure at MAX_BURST cycles.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] d,
  output logic [N_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic [W-1:0]       f
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

  logic             state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             valid_d;
  logic             take;
  logic             burst_exp;

  logic [N_REQ-1:0] cand;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;

  // While granted, the owner never competes with itself; ptr already sits at sel+1.
  assign cand = (state_q == ST_GRANT) ? (req & ~gnt) : req;

  rr_pick8 u_pick (
    .req    (cand),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

`ifdef RR_BURST_LIMIT_EN
  localparam int             BW   = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  MAXB = BW'(MAX_BURST);

  logic [BW-1:0] burst_q;

  assign burst_exp = (burst_q == MAXB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else if (take) begin
      burst_q <= BW'(1);
    end else if (state_d == ST_IDLE) begin
      burst_q <= '0;
    end else if (burst_q != MAXB) begin
      burst_q <= burst_q + BW'(1);
    end
  end
`else
  assign burst_exp = 1'b0;
`endif

  // State register, including all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
    end
  end

  // Next state: release or an expired burst re-arbitrates at the same edge.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          take    = 1'b1;
        end
      end
      default: begin
        if (!req[sel] || burst_exp) begin
          if (pick_any) begin
            take = 1'b1;
          end else if (!req[sel]) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;
    ptr_d   = ptr_q;
    if (take) begin
      gnt_d   = pick_oh;
      sel_d   = pick_idx;
      valid_d = 1'b1;
      ptr_d   = pick_idx + SEL_W'(1);
    end else if (state_d == ST_IDLE) begin
      gnt_d   = '0;
      sel_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    f = '0;
    if (valid) f = d[sel*W +: W];
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

  localparam int W  = 4;
  localparam int MB = 4;
  localparam int DW = 8 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    req = '0;
  logic [DW-1:0] d = '0;
  logic [7:0]    gnt;
  logic [2:0]    sel;
  logic          valid;
  logic [W-1:0]  f;

  int checks = 0;
  int failures = 0;

  int owner;
  int mptr;
`ifdef RR_BURST_LIMIT_EN
  int mburst;
`endif

  logic [7:0]   exp_gnt;
  logic [2:0]   exp_sel;
  logic         exp_valid;
  logic [W-1:0] exp_f;

  mux8_rr_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .f     (f)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int scan(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    mptr  = 0;
`ifdef RR_BURST_LIMIT_EN
    mburst = 0;
`endif
  endtask

  task automatic model_grant(input int w);
    owner = w;
    mptr  = (w + 1) % 8;
`ifdef RR_BURST_LIMIT_EN
    mburst = 1;
`endif
  endtask

  task automatic model_expect();
    exp_valid = (owner >= 0);
    exp_gnt   = exp_valid ? (8'(1) << owner) : 8'h00;
    exp_sel   = exp_valid ? 3'(owner) : 3'd0;
    exp_f     = exp_valid ? d[owner*W +: W] : '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic step(input logic [7:0] r, input logic [DW-1:0] dv);
    int w;
    logic [7:0] oth;
    req = r;
    d   = dv;
    @(posedge clk);
    if (owner < 0) begin
      w = scan(r, mptr);
      if (w >= 0) model_grant(w);
    end else if (!r[owner]) begin
      w = scan(r, mptr);
      if (w >= 0) model_grant(w);
      else model_reset_owner();
    end else begin
      oth = r & ~(8'(1) << owner);
`ifdef RR_BURST_LIMIT_EN
      if (mburst == MB && oth != 0) model_grant(scan(oth, (owner + 1) % 8));
      else if (mburst < MB) mburst++;
`else
      if (oth == 8'hFF) owner = owner;
`endif
    end
    #1;
    model_expect();
  endtask

  task automatic model_reset_owner();
    owner = -1;
`ifdef RR_BURST_LIMIT_EN
    mburst = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_expect();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    d     = '1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 8'h00) begin failures++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++;
    if (f !== '0) begin failures++; $display("FAIL reset_f got=%h exp=0", f); end
    checks++;
    if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    rst_n = 1'b1;
    step(8'hFF, '1);
    checks++;
    if (gnt !== 8'h01) begin failures++; $display("FAIL reset_release_gnt got=%h exp=01", gnt); end
    checks++;
    if (f !== '1) begin failures++; $display("FAIL reset_release_f got=%h exp=%h", f, {W{1'b1}}); end
  endtask

  task automatic test_rotation();
    do_reset();
    step(8'hFF, DW'($urandom));
    checks++;
    if (gnt !== 8'h01) begin failures++; $display("FAIL rot_first got=%h exp=01", gnt); end
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF & ~exp_gnt, DW'($urandom));
      checks++;
      if (gnt !== (8'(1) << (k % 8)) || valid !== 1'b1) begin
        failures++;
        $display("FAIL rot_step%0d got=%h/%b exp=%h/1", k, gnt, valid, 8'(1) << (k % 8));
      end
      checks++;
      if (f !== exp_f) begin failures++; $display("FAIL rot_f%0d got=%h exp=%h", k, f, exp_f); end
    end
  endtask

  task automatic test_hold_mux();
    logic [DW-1:0] dv;
    dv = '0;
    dv[5*W +: W] = W'(1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(8'h20, dv);
      checks++;
      if (sel !== 3'd5 || f !== W'(1) || gnt !== 8'h20) begin
        failures++;
        $display("FAIL hold_c%0d got sel=%0d f=%h gnt=%h exp sel=5 f=1 gnt=20", k, sel, f, gnt);
      end
    end
    step(8'h00, dv);
    checks++;
    if (valid !== 1'b0 || gnt !== 8'h00 || f !== '0) begin
      failures++;
      $display("FAIL hold_drop got valid=%b gnt=%h f=%h exp 0/00/0", valid, gnt, f);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    step(8'h04, '1);
    checks++;
    if (gnt !== 8'h04) begin failures++; $display("FAIL fair_setup got=%h exp=04", gnt); end
    step(8'h09, '1);
    checks++;
    if (gnt !== 8'h08) begin failures++; $display("FAIL fair_ptr3 got=%h exp=08", gnt); end
    step(8'h01, '1);
    checks++;
    if (gnt !== 8'h01) begin failures++; $display("FAIL fair_release got=%h exp=01", gnt); end
    step(8'h81, '1);
    checks++;
    if (gnt !== 8'h01) begin failures++; $display("FAIL fair_hold got=%h exp=01", gnt); end
    step(8'h82, '1);
    checks++;
    if (gnt !== 8'h02) begin failures++; $display("FAIL fair_next_round got=%h exp=02", gnt); end
  endtask

  task automatic test_burst();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(8'h03, DW'($urandom));
      checks++;
`ifdef RR_BURST_LIMIT_EN
      if (gnt !== (8'(1) << ((k / 4) % 2))) begin
        failures++;
        $display("FAIL burst_pair_c%0d got=%h exp=%h", k, gnt, 8'(1) << ((k / 4) % 2));
      end
`else
      if (gnt !== 8'h01) begin failures++; $display("FAIL noburst_pair_c%0d got=%h exp=01", k, gnt); end
`endif
    end
    for (int k = 0; k < 10; k++) begin
      step(8'h01, DW'($urandom));
      checks++;
      if (gnt !== 8'h01) begin failures++; $display("FAIL burst_alone_c%0d got=%h exp=01", k, gnt); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) step(8'h40, DW'($urandom));
    checks++;
    if (sel !== 3'd6 || gnt !== 8'h40) begin
      failures++;
      $display("FAIL areset_setup got sel=%0d gnt=%h exp sel=6 gnt=40", sel, gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (gnt !== 8'h00 || valid !== 1'b0 || sel !== 3'd0 || f !== '0) begin
      failures++;
      $display("FAIL areset_mid got gnt=%h valid=%b sel=%0d f=%h exp 00/0/0/0", gnt, valid, sel, f);
    end
    #3;
    rst_n = 1'b1;
    step(8'hFF, DW'($urandom));
    checks++;
    if (gnt !== 8'h01) begin failures++; $display("FAIL areset_ptr got=%h exp=01", gnt); end
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    r = '0;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom & $urandom & $urandom);
        2: r = r;
        default: r = r & ~exp_gnt;
      endcase
      step(r, DW'($urandom));
      checks++;
      if (gnt !== exp_gnt || sel !== exp_sel || valid !== exp_valid || f !== exp_f) begin
        failures++;
        $display("FAIL rand_c%0d req=%h got gnt=%h sel=%0d v=%b f=%h exp gnt=%h sel=%0d v=%b f=%h",
                 k, r, gnt, sel, valid, f, exp_gnt, exp_sel, exp_valid, exp_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hold_mux();
    test_fairness();
    test_burst();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
